tile_scheduler: RTL and testbench
=================================

TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16: PE array edge, i.e. filters per filter group and output pixels per pixel tile.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: square kernel edge.
REQ-003 SHALL have parameter NO_CHANNEL, default 3: input channels.
REQ-004 SHALL have parameter NO_FILTER, default 32: output filters; must be a multiple of SYSTOLIC_SIZE.
REQ-005 SHALL have parameter OFM_SIZE, default 32: output feature map edge.
REQ-006 SHALL have parameters IFM_ADDR_W = 19, WGT_ADDR_W = 9 and OFM_ADDR_W = 22: address widths.
REQ-007 SHALL derive the following constants:
- K2C = KERNEL_SIZE*KERNEL_SIZE*NO_CHANNEL
- FG = NO_FILTER/SYSTOLIC_SIZE
- PT = ceil(OFM_SIZE*OFM_SIZE/SYSTOLIC_SIZE)
- CC = K2C + 2*SYSTOLIC_SIZE - 2
REQ-008 clk  in  1  single clock; all logic is rising-edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 start  in  1  begins a layer; sampled only in IDLE.
REQ-011 abort  in  1  synchronous cancel of the current layer.
REQ-012 load_req  out  1  requests that the ifm/wgt fill units load the current tile.
REQ-013 load_ack  in  1  one-cycle pulse from the fill units: tile loaded.
REQ-014 ifm_tile  out  IFM_ADDR_W  current pixel-tile index.
REQ-015 wgt_base  out  WGT_ADDR_W  equals fg*K2C.
REQ-016 reset_pe  out  1  clears the PE accumulators.
REQ-017 compute_en  out  1  shift/MAC enable to the RFs and PE array.
REQ-018 ofm_ready  in  1  the ofm memory can accept a write.
REQ-019 write_out_en  out  1  ofm write strobe.
REQ-020 ofm_addr  out  OFM_ADDR_W  equals fg*PT*SYSTOLIC_SIZE + pt*SYSTOLIC_SIZE + d.
REQ-021 busy  out  1  high whenever state is not IDLE.
REQ-022 done  out  1  one-cycle pulse at layer completion.

Function
REQ-023 SHALL implement the states IDLE, LOAD, CLEAR, COMPUTE, DRAIN, NEXT and DONE.
REQ-024 IDLE SHALL go to LOAD when start=1, and SHALL clear fg, pt and d to 0 on that transition.
REQ-025 LOAD SHALL hold load_req=1 with ifm_tile and wgt_base stable, and SHALL go to CLEAR on the first cycle load_ack=1; load_ack outside LOAD SHALL be ignored.
REQ-026 CLEAR SHALL assert reset_pe=1 for exactly one cycle, then go to COMPUTE.
REQ-027 COMPUTE SHALL assert compute_en=1 for exactly CC consecutive cycles, then go to DRAIN with d=0.
REQ-028 DRAIN write strobe and address:
- write_out_en = (state==DRAIN) & ofm_ready, combinational.
- d SHALL increment only on cycles with write_out_en=1.
REQ-029 DRAIN SHALL go to NEXT after the write with d=SYSTOLIC_SIZE-1; ofm_ready=0 SHALL stall DRAIN indefinitely with no write and no address change.
REQ-030 NEXT SHALL take exactly one cycle and advance the loops (filter group inner, pixel tile outer):
- fg<FG-1: fg+1, then LOAD.
- Otherwise fg=0 and pt+1, then LOAD.
- When fg=FG-1 and pt=PT-1: go to DONE instead.
REQ-031 DONE SHALL assert done=1 for one cycle, then go to IDLE; start in the DONE cycle SHALL be ignored.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge, with no done pulse, and all strobes SHALL be 0 from that edge.
REQ-034 If abort=1 and start=1 arrive together in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-035 Address arithmetic:
- unsigned, truncated to the port width;
- computed from registered fg, pt and d;
- valid throughout every state other than IDLE.
REQ-036 load_req, reset_pe, compute_en, busy and done SHALL be registered; only write_out_en may depend combinationally on an input.
REQ-037 Exactly FG*PT tiles SHALL be processed per layer, giving FG*PT*SYSTOLIC_SIZE writes in total.

Reset
REQ-038 rst=1 SHALL force, at the next edge:
- state = IDLE;
- fg = pt = d = 0 and all counters 0;
- all outputs 0.
REQ-039 rst SHALL take priority over start, abort and load_ack; a reset mid-layer SHALL discard the layer with no done pulse.

Verification
Scenarios use SYSTOLIC_SIZE=4, KERNEL_SIZE=3, NO_CHANNEL=1, NO_FILTER=8, OFM_SIZE=4, giving K2C=9, FG=2, PT=4, CC=15.
REQ-040 Nominal run: start pulse, load_ack 2 cycles after each load_req, ofm_ready=1 -> expected response:
- 8 tiles processed;
- 32 writes with ofm_addr sequence 0-3, 16-19, 4-7, 20-23, 8-11, 24-27, 12-15, 28-31;
- wgt_base alternates 0,9;
- one done pulse, then busy=0.
REQ-041 Cycle timing -> load_ack to the first compute_en cycle = 2 cycles (through CLEAR); compute_en high for exactly 15 cycles per tile; reset_pe high for exactly 1 cycle per tile.
REQ-042 Backpressure: ofm_ready low for 5 cycles in the middle of the first DRAIN -> no writes during the stall, d holds, ofm_addr holds at 2; the sequence resumes at 2, 3 and finishes normally.
REQ-043 Abort during the 3rd COMPUTE -> IDLE next cycle, all strobes 0, no done; a fresh start then repeats the REQ-040 sequence from ofm_addr 0.
REQ-044 rst=1 during DRAIN with start held high -> all outputs 0 and IDLE next cycle; start is honoured only after rst falls; start pulses while busy produce no change.

Source files
------------

// File: rtl/tile_scheduler.sv
// Tile-level sequencer for a systolic conv engine: walks filter groups (inner) and pixel
// tiles (outer), handshaking tile loads, PE clear, compute window and ofm drain.
module tile_scheduler #(
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned NO_CHANNEL    = 3,
  parameter int unsigned NO_FILTER     = 32,
  parameter int unsigned OFM_SIZE      = 32,
  parameter int unsigned IFM_ADDR_W    = 19,
  parameter int unsigned WGT_ADDR_W    = 9,
  parameter int unsigned OFM_ADDR_W    = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  load_req,
  input  logic                  load_ack,
  output logic [IFM_ADDR_W-1:0] ifm_tile,
  output logic [WGT_ADDR_W-1:0] wgt_base,
  output logic                  reset_pe,
  output logic                  compute_en,
  input  logic                  ofm_ready,
  output logic                  write_out_en,
  output logic [OFM_ADDR_W-1:0] ofm_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned K2C  = KERNEL_SIZE * KERNEL_SIZE * NO_CHANNEL;
  localparam int unsigned FG   = NO_FILTER / SYSTOLIC_SIZE;
  localparam int unsigned PT   = (OFM_SIZE * OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int unsigned CC   = K2C + 2 * SYSTOLIC_SIZE - 2;

  localparam int unsigned FG_W = (FG > 1) ? $clog2(FG) : 1;
  localparam int unsigned PT_W = (PT > 1) ? $clog2(PT) : 1;
  localparam int unsigned D_W  = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int unsigned CC_W = $clog2(CC + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StClear,
    StCompute,
    StDrain,
    StNext,
    StDone
  } state_e;

  state_e          state_q;
  logic [FG_W-1:0] fg_q;
  logic [PT_W-1:0] pt_q;
  logic [D_W-1:0]  d_q;
  logic [CC_W-1:0] cnt_q;

  // The only output allowed to follow an input combinationally.
  assign write_out_en = (state_q == StDrain) & ofm_ready;

  assign ifm_tile = IFM_ADDR_W'(pt_q);
  assign wgt_base = WGT_ADDR_W'(fg_q) * WGT_ADDR_W'(K2C);
  assign ofm_addr = OFM_ADDR_W'(fg_q) * OFM_ADDR_W'(PT * SYSTOLIC_SIZE)
                  + OFM_ADDR_W'(pt_q) * OFM_ADDR_W'(SYSTOLIC_SIZE)
                  + OFM_ADDR_W'(d_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fg_q       <= '0;
      pt_q       <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      load_req   <= 1'b0;
      reset_pe   <= 1'b0;
      compute_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && (state_q != StIdle)) begin
      state_q    <= StIdle;
      load_req   <= 1'b0;
      reset_pe   <= 1'b0;
      compute_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            state_q  <= StLoad;
            fg_q     <= '0;
            pt_q     <= '0;
            d_q      <= '0;
            load_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StLoad: begin
          if (load_ack) begin
            state_q  <= StClear;
            load_req <= 1'b0;
            reset_pe <= 1'b1;
          end
        end
        StClear: begin
          state_q    <= StCompute;
          reset_pe   <= 1'b0;
          compute_en <= 1'b1;
          cnt_q      <= '0;
        end
        StCompute: begin
          if (cnt_q == CC_W'(CC - 1)) begin
            state_q    <= StDrain;
            compute_en <= 1'b0;
            d_q        <= '0;
          end else begin
            cnt_q <= cnt_q + CC_W'(1);
          end
        end
        StDrain: begin
          if (ofm_ready) begin
            if (d_q == D_W'(SYSTOLIC_SIZE - 1)) begin
              state_q <= StNext;
            end else begin
              d_q <= d_q + D_W'(1);
            end
          end
        end
        StNext: begin
          d_q <= '0;
          if (fg_q != FG_W'(FG - 1)) begin
            fg_q     <= fg_q + FG_W'(1);
            state_q  <= StLoad;
            load_req <= 1'b1;
          end else if (pt_q != PT_W'(PT - 1)) begin
            fg_q     <= '0;
            pt_q     <= pt_q + PT_W'(1);
            state_q  <= StLoad;
            load_req <= 1'b1;
          end else begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          load_req   <= 1'b0;
          reset_pe   <= 1'b0;
          compute_en <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler with a 4x4 array, 8 filters, 4x4 ofm (FG=2, PT=4, CC=15).
module tb_tile_scheduler;

  localparam int S = 4;
  localparam int K = 3;
  localparam int C = 1;
  localparam int F = 8;
  localparam int O = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        load_ack;
  logic        ofm_ready;
  logic        load_req;
  logic [18:0] ifm_tile;
  logic [8:0]  wgt_base;
  logic        reset_pe;
  logic        compute_en;
  logic        write_out_en;
  logic [21:0] ofm_addr;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  // Tile order: pixel tile outer, filter group inner.
  int exp_base [8] = '{0, 16, 4, 20, 8, 24, 12, 28};
  int exp_wgt  [8] = '{0, 9, 0, 9, 0, 9, 0, 9};
  int exp_tile [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  tile_scheduler #(
    .SYSTOLIC_SIZE(S),
    .KERNEL_SIZE  (K),
    .NO_CHANNEL   (C),
    .NO_FILTER    (F),
    .OFM_SIZE     (O)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .load_req    (load_req),
    .load_ack    (load_ack),
    .ifm_tile    (ifm_tile),
    .wgt_base    (wgt_base),
    .reset_pe    (reset_pe),
    .compute_en  (compute_en),
    .ofm_ready   (ofm_ready),
    .write_out_en(write_out_en),
    .ofm_addr    (ofm_addr),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic s, input logic a, input logic ack, input logic rdy);
    @(posedge clk);
    #1;
    start     = s;
    abort     = a;
    load_ack  = ack;
    ofm_ready = rdy;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_load_req"}, 32'(load_req), 0);
    check({tag, "_reset_pe"}, 32'(reset_pe), 0);
    check({tag, "_compute_en"}, 32'(compute_en), 0);
    check({tag, "_write_out_en"}, 32'(write_out_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Acts as fill unit and ofm sink for one layer: ack 2 cycles after load_req rises.
  task automatic run_layer(input bit stall, input int abort_tile, input bit spam,
                           input int exp_writes, input int exp_dones, input int exp_tiles);
    int   cyc = 0, writes = 0, dones = 0, tiles = 0, lr_cnt = 0, ack_cyc = -100;
    int   cr = 0, rr = 0, stall_left = 0;
    bit   stall_done = 0, abort_seen = 0, finished = 0;
    logic n_start, n_abort, n_ack, n_rdy;
    apply(1'b1, 1'b0, 1'b0, 1'b1);
    while (cyc < 1000 && !finished) begin
      @(negedge clk);
      cyc++;
      n_start = spam;
      n_abort = 1'b0;
      n_ack   = 1'b0;
      n_rdy   = ofm_ready;
      if (abort_seen) begin
        check_quiet("after_abort");
        finished = 1;
      end else begin
        if (abort) abort_seen = 1;
        if (load_req) begin
          lr_cnt++;
          if (lr_cnt == 1) begin
            if (tiles < 8) begin
              check("wgt_base", 32'(wgt_base), exp_wgt[tiles]);
              check("ifm_tile", 32'(ifm_tile), exp_tile[tiles]);
            end else begin
              check("tile_count_overrun", tiles, 7);
            end
            tiles++;
          end
          if (lr_cnt == 2) n_ack = 1'b1;
        end else begin
          lr_cnt = 0;
        end
        if (load_ack) ack_cyc = cyc;
        if (reset_pe) rr++;
        else if (rr > 0) begin
          check("reset_pe_len", rr, 1);
          rr = 0;
        end
        if (compute_en) begin
          if (cr == 0) check("ack_to_compute", cyc - ack_cyc, 2);
          cr++;
          if (abort_tile == tiles && cr == 3) n_abort = 1'b1;
        end else if (cr > 0) begin
          check("compute_len", cr, 15);
          cr = 0;
        end
        if (stall_left > 0) begin
          check("stall_no_write", 32'(write_out_en), 0);
          check("stall_addr_hold", 32'(ofm_addr), 2);
          stall_left--;
          if (stall_left == 0) n_rdy = 1'b1;
        end else if (write_out_en) begin
          if (writes < 32) check("ofm_addr", 32'(ofm_addr), exp_base[writes / 4] + writes % 4);
          writes++;
          if (stall && !stall_done && writes == 2) begin
            n_rdy      = 1'b0;
            stall_left = 5;
            stall_done = 1;
          end
        end
        if (dones > 0 && !done) begin
          check("busy_after_done", 32'(busy), 0);
          finished = 1;
        end
        if (done) dones++;
      end
      if (dones > 0) n_start = 1'b0;
      if (!finished) apply(n_start, n_abort, n_ack, n_rdy);
    end
    start     = 1'b0;
    abort     = 1'b0;
    load_ack  = 1'b0;
    ofm_ready = 1'b1;
    check("layer_finished", 32'(finished), 1);
    check("writes", writes, exp_writes);
    check("dones", dones, exp_dones);
    check("tiles", tiles, exp_tiles);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    load_ack  = 1'b0;
    ofm_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_ofm_addr", 32'(ofm_addr), 0);
    check("reset_wgt_base", 32'(wgt_base), 0);
    check("reset_ifm_tile", 32'(ifm_tile), 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal layer.
    run_layer(1'b0, 0, 1'b0, 32, 1, 8);
    repeat (2) @(negedge clk);

    // Backpressure in the first drain.
    run_layer(1'b1, 0, 1'b0, 32, 1, 8);
    repeat (2) @(negedge clk);

    // Abort in the third compute, then a clean layer.
    run_layer(1'b0, 3, 1'b0, 8, 0, 3);
    check("idle_after_abort_busy", 32'(busy), 0);
    run_layer(1'b0, 0, 1'b0, 32, 1, 8);
    repeat (2) @(negedge clk);

    // Abort together with start in idle: stays idle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_beats_start_busy", 32'(busy), 0);
    check("abort_beats_start_load_req", 32'(load_req), 0);

    // Reset in drain with start held high.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !write_out_en; i++) begin
      load_ack = load_req && !load_ack;
      @(negedge clk);
    end
    load_ack = 1'b0;
    check("reached_drain", 32'(write_out_en), 1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_quiet("rst_mid");
    check("rst_mid_ofm_addr", 32'(ofm_addr), 0);
    check("rst_mid_wgt_base", 32'(wgt_base), 0);
    check("rst_mid_ifm_tile", 32'(ifm_tile), 0);
    @(negedge clk);
    check("rst_hold_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("start_after_rst_busy", 32'(busy), 1);
    check("start_after_rst_load_req", 32'(load_req), 1);
    @(negedge clk);
    check("start_while_busy_load_req", 32'(load_req), 1);
    check("start_while_busy_ifm_tile", 32'(ifm_tile), 0);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_load_busy", 32'(busy), 0);
    @(negedge clk);

    // Full layer with start asserted on every busy cycle, including the done cycle.
    run_layer(1'b0, 0, 1'b1, 32, 1, 8);
    repeat (2) @(negedge clk);
    check("final_idle_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
